// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative shift-add MULT/MULTU sequencer driving a shared
// external WIDTH-bit combinational adder. Produces a 2*WIDTH product on hi/lo.
//
// Build option: define MULT_SIGNED_EN to honour signed_op. This adds the
// absolute-value and negate states. Without it every operation is unsigned.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start, adder operands held at zero
// ABS_A   | multiplicand made positive if a signed operand is negative
// ABS_B   | multiplier made positive if a signed operand is negative
// MUL     | one shift-add iteration per cycle, WIDTH iterations
// NEG_LO  | low product word two's-complemented, carry latched
// NEG_HI  | high product word complemented plus latched carry
// DONE    | hi/lo valid, done pulses, a new start is accepted here
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  input  logic [WIDTH-1:0] add_sum_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MULT_SIGNED_EN
    S_ABS_A,
    S_ABS_B,
    S_NEG_LO,
    S_NEG_HI,
`endif
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef MULT_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             c_q, c_d;
`else
  logic             unused_signed_op;
  assign unused_signed_op = signed_op_i;
`endif

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
`ifdef MULT_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
`endif
    end
  end

  // Next-state logic, adder operand selection and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    add_a_o = '0;
    add_b_o = '0;
`ifdef MULT_SIGNED_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    c_d     = c_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          a_d    = op_a_i;
          p_lo_d = op_b_i;
          p_hi_d = '0;
          cnt_d  = CNT_LOAD;
`ifdef MULT_SIGNED_EN
          sgn_d   = signed_op_i;
          neg_d   = signed_op_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
          state_d = S_ABS_A;
`else
          state_d = S_MUL;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef MULT_SIGNED_EN
      S_ABS_A: begin
        if (sgn_q && a_q[WIDTH-1]) begin
          add_a_o = ~a_q;
          add_b_o = ONE;
          a_d     = add_sum_i;
        end else begin
          add_a_o = a_q;
        end
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        if (sgn_q && p_lo_q[WIDTH-1]) begin
          add_a_o = ~p_lo_q;
          add_b_o = ONE;
          p_lo_d  = add_sum_i;
        end else begin
          add_a_o = p_lo_q;
        end
        state_d = S_MUL;
      end
`endif
      S_MUL: begin
        add_a_o = p_hi_q;
        add_b_o = p_lo_q[0] ? a_q : '0;
        // Adder carry-out recovered from the sum wrapping below operand A.
        p_hi_d  = {(add_sum_i < p_hi_q), add_sum_i[WIDTH-1:1]};
        p_lo_d  = {add_sum_i[0], p_lo_q[WIDTH-1:1]};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
`ifdef MULT_SIGNED_EN
          state_d = S_NEG_LO;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      S_NEG_LO: begin
        if (neg_q) begin
          add_a_o = ~p_lo_q;
          add_b_o = ONE;
          p_lo_d  = add_sum_i;
          c_d     = add_sum_i < ~p_lo_q;
        end else begin
          add_a_o = p_lo_q;
          c_d     = 1'b0;
        end
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (neg_q) begin
          add_a_o = ~p_hi_q;
          add_b_o = {{(WIDTH-1){1'b0}}, c_q};
          p_hi_d  = add_sum_i;
        end else begin
          add_a_o = p_hi_q;
        end
        state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Result registers load on entry to DONE with the final product.
    if (state_d == S_DONE && state_q != S_DONE) begin
      hi_d = p_hi_d;
      lo_d = p_lo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: stimulus pushes expected hi/lo and done
// cycle; a negedge monitor pops and compares whenever done is presented.
module tb_mult_seq_ctrl;
  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam int LAT = 36;
  localparam logic [31:0] NEG3_HI = 32'hFFFF_FFFF;
`else
  localparam int LAT = 32;
  localparam logic [31:0] NEG3_HI = 32'h0000_0004;
`endif
  localparam int PRE = LAT - 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] add_a, add_b, add_sum, hi, lo;
  logic         busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          when;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .signed_op_i(signed_op),
    .op_a_i(op_a), .op_b_i(op_b), .add_a_o(add_a), .add_b_o(add_b),
    .add_sum_i(add_sum), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  // External shared adder model.
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        m = sb.pop_front();
        chk("hi", hi, m.hi);
        chk("lo", lo, m.lo);
        chk("done_cycle", cyc, m.when);
      end
    end
  end

  // Caller is at a negedge; start is sampled on the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eh, input logic [31:0] el, input bit track);
    exp_t e;
    start = 1'b1;
    op_a = a;
    op_b = b;
    signed_op = s;
    if (track) begin
      e.hi = eh;
      e.lo = el;
      e.when = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'hCAFE_F00D;
    signed_op = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3*5 unsigned, busy high for the whole operation.
    issue(32'd3, 32'd5, 1'b0, 32'h0, 32'h0000_000F, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      chk("busy_during_op", busy, 1);
      @(negedge clk);
    end
    chk("busy_in_done", busy, 0);
    chk("add_a_in_done", add_a, 0);
    wait_done();

    // Full-scale unsigned, carry path.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_done();

    // Signed cases.
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, NEG3_HI, 32'hFFFF_FFF1, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 1'b1);
    wait_done();

    // Start pulsed during MUL is ignored.
    issue(32'd3, 32'd5, 1'b0, 32'h0, 32'h0000_000F, 1'b1);
    repeat (PRE + 4) @(negedge clk);
    start = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (50) @(negedge clk);
    chk("ignored_start_lo", lo, 32'h0000_000F);

    // Reset during MUL iteration 10: abandoned, no done.
    issue(32'h0000_1234, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (PRE + 10) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    issue(32'd7, 32'd6, 1'b0, 32'h0, 32'h0000_002A, 1'b1);
    wait_done();

    // Back-to-back: new start presented in the DONE cycle.
    issue(32'd3, 32'd5, 1'b0, 32'h0, 32'h0000_000F, 1'b1);
    repeat (LAT) @(negedge clk);
    chk("b2b_done_cycle", done, 1);
    issue(32'd2, 32'd2, 1'b0, 32'h0, 32'h0000_0004, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
